nw_job_arbiter: RTL and testbench
=================================

Name: nw_job_arbiter

Overview:
- Shares one needleman_wunsch alignment core between NUM_REQ independent requesters.
- Round-robin arbitration over request channels; latches the winner's sequences, pulses the core start, waits for core done or timeout, then returns the result tagged with the requester id.
- Sits between the host/DMA request ports and a single core instance that uses start/done handshaking.

Parameters:
- NUM_REQ, 4, number of requester ports; 2..8.
- REF_LEN, 15, reference length in bases.
- QUERY_LEN, 10, query length in bases.
- BASE_WIDTH, 2, bits per base (A=00, T=01, G=10, C=11).
- ALIGN_LEN, REF_LEN+QUERY_LEN, maximum aligned length in bases.
- TIMEOUT_CYC, 1024, maximum RUN cycles before the job is aborted.
- ID_W, clog2(NUM_REQ) (minimum 1), requester id width.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- req_valid  in  NUM_REQ  per-requester job valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_ref_seq  in  NUM_REQ*REF_LEN*BASE_WIDTH  packed reference per requester; slot i at [i*REF_LEN*BASE_WIDTH +: REF_LEN*BASE_WIDTH].
- req_query_seq  in  NUM_REQ*QUERY_LEN*BASE_WIDTH  packed query per requester; same slot layout.
- core_start  out  1  one-cycle start pulse to the core.
- core_ref_seq  out  REF_LEN*BASE_WIDTH  latched reference to the core.
- core_query_seq  out  QUERY_LEN*BASE_WIDTH  latched query to the core.
- core_done  in  1  core completion, one cycle.
- core_aligned_ref  in  ALIGN_LEN*BASE_WIDTH  core result, valid when core_done=1.
- core_aligned_query  in  ALIGN_LEN*BASE_WIDTH  core result, valid when core_done=1.
- core_alignment_length  in  8  core result, valid when core_done=1.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accept.
- rsp_id  out  ID_W  id of the requester that owns the result.
- rsp_aligned_ref  out  ALIGN_LEN*BASE_WIDTH  aligned reference.
- rsp_aligned_query  out  ALIGN_LEN*BASE_WIDTH  aligned query.
- rsp_length  out  8  aligned length in bases.
- rsp_timeout  out  1  job aborted on timeout; data fields are 0.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE; round-robin pointer goes to 0.
  - All outputs go to 0: req_ready, core_start, core_* data, all rsp_* fields, busy.
  - Reset overrides every state. A job in flight is dropped; any later core_done is ignored while in IDLE.
- FSM states: IDLE, START, RUN, RESP.
- IDLE:
  - Grant = first asserted req_valid at or after the pointer, searching upward and wrapping modulo NUM_REQ.
  - req_ready[grant]=1 combinationally; no grant means req_ready=0.
  - On handshake at edge T: latch sequences and id, set pointer=(grant+1) mod NUM_REQ, go to START.
- START (cycle T+1): core_start=1 for exactly this cycle, with core_ref_seq/core_query_seq already stable. Next state RUN; timeout counter cleared to 0.
- RUN:
  - Counter increments each cycle.
  - If core_done=1: capture the results, rsp_timeout=0, go to RESP.
  - Else if counter reaches TIMEOUT_CYC-1: set all data fields to 0, rsp_timeout=1, go to RESP.
  - core_done in the same cycle as the limit counts as done, not timeout.
- RESP:
  - rsp_valid=1 and all rsp_* fields held stable until rsp_valid && rsp_ready; then return to IDLE.
  - rsp_valid drops the cycle after acceptance.
  - The next grant is possible in the first IDLE cycle; no back-to-back bypass from RESP.
- core_ref_seq/core_query_seq hold from START until the next grant; the core sees them stable for the whole job.
- core_done outside RUN is ignored.
- req_valid may drop without a handshake. No requirement applies to requesters, but the data of a granted slot is sampled only at the handshake edge.
- Minimum job turnaround is 4 cycles: IDLE, START, RUN (done on the first RUN cycle), RESP with rsp_ready=1.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,NUM_REQ-1,0.

Decomposition:
- Package nw_pkg holds:
  - base encoding constants BASE_A/T/G/C;
  - the FSM state typedef (IDLE, START, RUN, RESP);
  - default REF_LEN/QUERY_LEN/BASE_WIDTH;
  - the clog2 helper.
- One sub-module, nw_rr_arbiter: combinational round-robin grant from (req_valid, pointer) to (grant_valid, grant_id). Pointer state stays in nw_job_arbiter.

Test Plan:
- Reset mid-RUN: rst=0 for 1 cycle while in RUN → next cycle busy=0, rsp_valid=0, pointer=0; a stray core_done 3 cycles later produces no response.
- Single job:
  - Stimulus: req_valid[2]=1 with ref=15-base GTATGCATTGCATGG encoding and query=ATGCATTGCA; stub core raises done 20 cycles after start with length 17.
  - Required: req_ready[2] at the handshake; core_start exactly 1 cycle, the cycle after the handshake; rsp_valid on the cycle after done with rsp_id=2, rsp_length=17, rsp_timeout=0.
- Round-robin: all 4 req_valid held high, stub core done after 5 cycles, rsp_ready=1 → grant order 0,1,2,3,0; each job 8 cycles handshake-to-handshake.
- Timeout: TIMEOUT_CYC=16, stub never asserts done → rsp_valid exactly 16 RUN cycles after START, rsp_timeout=1, rsp_length=0, data zero.
- Backpressure: rsp_ready=0 for 10 cycles in RESP → rsp_* fields stable, req_ready all 0, busy=1; rsp_ready=1 → return to IDLE, next pending requester granted the following cycle.
- Done/timeout collision: core_done asserted on RUN cycle TIMEOUT_CYC → rsp_timeout=0 and core data captured.

Source files
------------

// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch job arbiter: base encoding,
// arbiter FSM states, default sequence geometry and a width helper.
package nw_pkg;

    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_T = 2'b01;
    localparam logic [1:0] BASE_G = 2'b10;
    localparam logic [1:0] BASE_C = 2'b11;

    localparam int DEF_REF_LEN    = 15;
    localparam int DEF_QUERY_LEN  = 10;
    localparam int DEF_BASE_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } nw_state_t;

    // Bits needed to index n items, never less than 1.
    function automatic int nw_clog2(input int n);
        int w;
        w = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/nw_rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or after the
// pointer, searching upward and wrapping modulo NUM_REQ.
module nw_rr_arbiter
    import nw_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = nw_clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    ptr,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        sum         = '0;
        idx         = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (ID_W + 1)'(k);
            if (sum >= (ID_W + 1)'(NUM_REQ)) begin
                sum = sum - (ID_W + 1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (req_valid[idx]) begin
                grant_valid = 1'b1;
                grant_id    = idx;
            end
        end
    end

endmodule

// File: rtl/nw_job_arbiter.sv
// Shares one Needleman-Wunsch core between NUM_REQ requesters: round-robin
// grant, latch the winner's sequences, pulse core start, wait for done or
// timeout, then hold the tagged result until the consumer accepts it.
module nw_job_arbiter
    import nw_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int REF_LEN     = DEF_REF_LEN,
    parameter int QUERY_LEN   = DEF_QUERY_LEN,
    parameter int BASE_WIDTH  = DEF_BASE_WIDTH,
    parameter int ALIGN_LEN   = REF_LEN + QUERY_LEN,
    parameter int TIMEOUT_CYC = 1024,
    parameter int ID_W        = nw_clog2(NUM_REQ)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ*REF_LEN*BASE_WIDTH-1:0] req_ref_seq,
    input  logic [NUM_REQ*QUERY_LEN*BASE_WIDTH-1:0] req_query_seq,
    output logic                                  core_start,
    output logic [REF_LEN*BASE_WIDTH-1:0]         core_ref_seq,
    output logic [QUERY_LEN*BASE_WIDTH-1:0]       core_query_seq,
    input  logic                                  core_done,
    input  logic [ALIGN_LEN*BASE_WIDTH-1:0]       core_aligned_ref,
    input  logic [ALIGN_LEN*BASE_WIDTH-1:0]       core_aligned_query,
    input  logic [7:0]                            core_alignment_length,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [ID_W-1:0]                       rsp_id,
    output logic [ALIGN_LEN*BASE_WIDTH-1:0]       rsp_aligned_ref,
    output logic [ALIGN_LEN*BASE_WIDTH-1:0]       rsp_aligned_query,
    output logic [7:0]                            rsp_length,
    output logic                                  rsp_timeout,
    output logic                                  busy
);

    localparam int REF_BITS = REF_LEN * BASE_WIDTH;
    localparam int QRY_BITS = QUERY_LEN * BASE_WIDTH;
    // One extra count of headroom so the increment on the final RUN cycle cannot wrap.
    localparam int CNT_W    = nw_clog2(TIMEOUT_CYC + 1);

    nw_state_t          state;
    logic [ID_W-1:0]    ptr;
    logic [CNT_W-1:0]   cnt;
    logic               grant_valid;
    logic [ID_W-1:0]    grant_id;
    logic [REF_BITS-1:0] sel_ref;
    logic [QRY_BITS-1:0] sel_query;

    nw_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req_valid   (req_valid),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Accept is offered only in IDLE, and never while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (rst && (state == IDLE) && grant_valid) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Select the granted requester's sequence slots.
    always_comb begin
        sel_ref   = '0;
        sel_query = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_ref   = req_ref_seq[i*REF_BITS +: REF_BITS];
                sel_query = req_query_seq[i*QRY_BITS +: QRY_BITS];
            end
        end
    end

    // Job FSM with registered core and response outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= IDLE;
            ptr               <= '0;
            cnt               <= '0;
            core_start        <= 1'b0;
            core_ref_seq      <= '0;
            core_query_seq    <= '0;
            rsp_valid         <= 1'b0;
            rsp_id            <= '0;
            rsp_aligned_ref   <= '0;
            rsp_aligned_query <= '0;
            rsp_length        <= '0;
            rsp_timeout       <= 1'b0;
            busy              <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        core_ref_seq   <= sel_ref;
                        core_query_seq <= sel_query;
                        rsp_id         <= grant_id;
                        ptr            <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                        core_start     <= 1'b1;
                        busy           <= 1'b1;
                        state          <= START;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    // Done wins over a timeout landing on the same cycle.
                    if (core_done) begin
                        rsp_aligned_ref   <= core_aligned_ref;
                        rsp_aligned_query <= core_aligned_query;
                        rsp_length        <= core_alignment_length;
                        rsp_timeout       <= 1'b0;
                        rsp_valid         <= 1'b1;
                        state             <= RESP;
                    end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        rsp_aligned_ref   <= '0;
                        rsp_aligned_query <= '0;
                        rsp_length        <= '0;
                        rsp_timeout       <= 1'b1;
                        rsp_valid         <= 1'b1;
                        state             <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nw_job_arbiter.sv
// Testbench for nw_job_arbiter: scenario tasks plus a randomized job stream
// checked against a round-robin / latency reference model and a stub core.
module tb_nw_job_arbiter;

    localparam int NR  = 4;
    localparam int RL  = 15;
    localparam int QL  = 10;
    localparam int BW  = 2;
    localparam int AL  = RL + QL;
    localparam int TO  = 24;
    localparam int IDW = 2;
    localparam int RB  = RL * BW;
    localparam int QB  = QL * BW;
    localparam int AB  = AL * BW;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*RB-1:0]  req_ref_seq = '0;
    logic [NR*QB-1:0]  req_query_seq = '0;
    logic              core_start;
    logic [RB-1:0]     core_ref_seq;
    logic [QB-1:0]     core_query_seq;
    logic              core_done = 1'b0;
    logic [AB-1:0]     core_aligned_ref = '0;
    logic [AB-1:0]     core_aligned_query = '0;
    logic [7:0]        core_alignment_length = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic [AB-1:0]     rsp_aligned_ref;
    logic [AB-1:0]     rsp_aligned_query;
    logic [7:0]        rsp_length;
    logic              rsp_timeout;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_ptr = 0;

    // Stub core controls
    int stub_delay = 5;
    int stub_cnt = 0;
    bit stub_en = 1'b1;
    bit force_done = 1'b0;

    nw_job_arbiter #(
        .NUM_REQ     (NR),
        .REF_LEN     (RL),
        .QUERY_LEN   (QL),
        .BASE_WIDTH  (BW),
        .ALIGN_LEN   (AL),
        .TIMEOUT_CYC (TO),
        .ID_W        (IDW)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_ref_seq           (req_ref_seq),
        .req_query_seq         (req_query_seq),
        .core_start            (core_start),
        .core_ref_seq          (core_ref_seq),
        .core_query_seq        (core_query_seq),
        .core_done             (core_done),
        .core_aligned_ref      (core_aligned_ref),
        .core_aligned_query    (core_aligned_query),
        .core_alignment_length (core_alignment_length),
        .rsp_valid             (rsp_valid),
        .rsp_ready             (rsp_ready),
        .rsp_id                (rsp_id),
        .rsp_aligned_ref       (rsp_aligned_ref),
        .rsp_aligned_query     (rsp_aligned_query),
        .rsp_length            (rsp_length),
        .rsp_timeout           (rsp_timeout),
        .busy                  (busy)
    );

    always #5 clk = ~clk;

    // Stub core: done pulses stub_delay cycles after the start cycle.
    always @(negedge clk) begin
        core_done = 1'b0;
        if (core_start === 1'b1) begin
            stub_cnt = stub_delay;
        end else if (stub_cnt > 0) begin
            stub_cnt = stub_cnt - 1;
            if (stub_cnt == 0 && stub_en) core_done = 1'b1;
        end
        if (force_done) core_done = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference: first valid requester at or after ptr, wrapping.
    function automatic int model_grant(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int g);
        logic [NR-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] enc(input string s);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "A": r[i*2 +: 2] = 2'b00;
                "T": r[i*2 +: 2] = 2'b01;
                "G": r[i*2 +: 2] = 2'b10;
                default: r[i*2 +: 2] = 2'b11;
            endcase
        end
        return r;
    endfunction

    task automatic rand_slots();
        for (int i = 0; i < NR; i++) begin
            req_ref_seq[i*RB +: RB]   = RB'($urandom());
            req_query_seq[i*QB +: QB] = QB'($urandom());
        end
    endtask

    task automatic rand_core();
        core_aligned_ref      = AB'({$urandom(), $urandom()});
        core_aligned_query    = AB'({$urandom(), $urandom()});
        core_alignment_length = 8'($urandom_range(1, AL));
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = '0;
        tick();
        req_valid = '1;
        tick();
        checks++; if ({busy, rsp_valid, core_start} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b exp 000", {busy, rsp_valid, core_start}); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
        checks++; if ({core_ref_seq, core_query_seq, rsp_id, rsp_aligned_ref, rsp_aligned_query, rsp_length, rsp_timeout} !== '0) begin errors++; $display("FAIL reset_data got nonzero exp 0"); end
        req_valid = '0;
        rst = 1'b1;
        model_ptr = 0;
        tick();
    endtask

    task automatic test_single_job();
        logic [63:0] t;
        logic [RB-1:0] er;
        logic [QB-1:0] eq;
        logic [AB-1:0] ear, eaq;
        int n;
        rand_slots();
        t = enc("GTATGCATTGCATGG"); er = t[RB-1:0];
        t = enc("ATGCATTGCA");      eq = t[QB-1:0];
        req_ref_seq[2*RB +: RB] = er;
        req_query_seq[2*QB +: QB] = eq;
        rand_core();
        core_alignment_length = 8'd17;
        ear = core_aligned_ref; eaq = core_aligned_query;
        stub_en = 1'b1; stub_delay = 20; rsp_ready = 1'b0;
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== onehot(model_grant(req_valid, model_ptr))) begin errors++; $display("FAIL single_ready got %b exp 0100", req_ready); end
        tick();
        model_ptr = 3;
        req_valid = '0;
        checks++; if ({core_start, busy, core_ref_seq, core_query_seq} !== {2'b11, er, eq}) begin errors++; $display("FAIL single_start got %b %b %h %h exp 1 1 %h %h", core_start, busy, core_ref_seq, core_query_seq, er, eq); end
        tick();
        checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL single_start_width got %b exp 0", core_start); end
        n = 1;
        while (rsp_valid !== 1'b1 && n < 60) begin tick(); n++; end
        checks++; if (n !== 21) begin errors++; $display("FAIL single_latency got %0d exp 21", n); end
        checks++; if ({rsp_id, rsp_length, rsp_timeout} !== {2'd2, 8'd17, 1'b0}) begin errors++; $display("FAIL single_rsp got id %0d len %0d to %b exp 2 17 0", rsp_id, rsp_length, rsp_timeout); end
        checks++; if ({rsp_aligned_ref, rsp_aligned_query} !== {ear, eaq}) begin errors++; $display("FAIL single_data got %h %h exp %h %h", rsp_aligned_ref, rsp_aligned_query, ear, eaq); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL single_release got %b exp 00", {rsp_valid, busy}); end
    endtask

    task automatic test_reset_mid_run();
        rand_slots();
        stub_en = 1'b1; stub_delay = 7; rsp_ready = 1'b0;
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== onehot(model_grant(req_valid, model_ptr))) begin errors++; $display("FAIL midrst_ready got %b exp %b", req_ready, onehot(model_grant(req_valid, model_ptr))); end
        tick();
        model_ptr = 2;
        req_valid = '0;
        checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL midrst_start got %b exp 1", core_start); end
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        model_ptr = 0;
        checks++; if ({busy, rsp_valid, core_start, core_ref_seq} !== '0) begin errors++; $display("FAIL midrst_clear got %b %b %b %h exp 0", busy, rsp_valid, core_start, core_ref_seq); end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL midrst_stray got %b exp 00", {rsp_valid, busy}); end
        end
        req_valid = '1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_ptr got %b exp 0001", req_ready); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_round_robin();
        int g, n, last;
        logic [RB-1:0] er;
        logic [AB-1:0] ear;
        last = 0;
        stub_en = 1'b1; stub_delay = 5; rsp_ready = 1'b1;
        rand_slots();
        req_valid = '1;
        for (int j = 0; j < 5; j++) begin
            #1;
            g = model_grant(req_valid, model_ptr);
            checks++; if (req_ready !== onehot(g)) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", j, req_ready, onehot(g)); end
            if (j > 0) begin
                checks++; if (cyc - last !== 8) begin errors++; $display("FAIL rr_period%0d got %0d exp 8", j, cyc - last); end
            end
            last = cyc;
            er = req_ref_seq[g*RB +: RB];
            tick();
            model_ptr = (g + 1) % NR;
            checks++; if ({core_start, core_ref_seq} !== {1'b1, er}) begin errors++; $display("FAIL rr_start%0d got %b %h exp 1 %h", j, core_start, core_ref_seq, er); end
            rand_core();
            ear = core_aligned_ref;
            n = 0;
            while (rsp_valid !== 1'b1 && n < 60) begin tick(); n++; end
            checks++; if ({n[7:0], rsp_id, rsp_aligned_ref} !== {8'd6, IDW'(g), ear}) begin errors++; $display("FAIL rr_rsp%0d got lat %0d id %0d exp 6 %0d", j, n, rsp_id, g); end
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int id, n;
        id = $urandom_range(0, NR - 1);
        stub_en = 1'b0; rsp_ready = 1'b0;
        rand_core();
        req_valid = onehot(id);
        #1;
        checks++; if (req_ready !== onehot(model_grant(req_valid, model_ptr))) begin errors++; $display("FAIL to_ready got %b exp %b", req_ready, onehot(id)); end
        tick();
        model_ptr = (id + 1) % NR;
        req_valid = '0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 80) begin tick(); n++; end
        checks++; if (n !== TO + 1) begin errors++; $display("FAIL to_latency got %0d exp %0d", n, TO + 1); end
        checks++; if ({rsp_timeout, rsp_id, rsp_length, rsp_aligned_ref, rsp_aligned_query} !== {1'b1, IDW'(id), 8'd0, {AB{1'b0}}, {AB{1'b0}}}) begin errors++; $display("FAIL to_fields got to %b id %0d len %0d exp 1 %0d 0", rsp_timeout, rsp_id, rsp_length, id); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        stub_en = 1'b1;
    endtask

    task automatic test_collision();
        int id, n;
        logic [AB-1:0] ear;
        logic [7:0] el;
        id = $urandom_range(0, NR - 1);
        stub_en = 1'b1; stub_delay = TO; rsp_ready = 1'b0;
        rand_core();
        ear = core_aligned_ref; el = core_alignment_length;
        req_valid = onehot(id);
        tick();
        model_ptr = (id + 1) % NR;
        req_valid = '0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 80) begin tick(); n++; end
        checks++; if (n !== TO + 1) begin errors++; $display("FAIL coll_latency got %0d exp %0d", n, TO + 1); end
        checks++; if ({rsp_timeout, rsp_length, rsp_aligned_ref} !== {1'b0, el, ear}) begin errors++; $display("FAIL coll_fields got to %b len %0d exp 0 %0d", rsp_timeout, rsp_length, el); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int a, b, g, n;
        logic [NR-1:0] mask;
        logic [RB-1:0] er;
        logic [AB-1:0] ear, eaq;
        logic [7:0] el;
        a = $urandom_range(0, NR - 1);
        b = (a + $urandom_range(1, NR - 1)) % NR;
        mask = onehot(a) | onehot(b);
        rand_slots();
        stub_en = 1'b1; stub_delay = $urandom_range(1, 8); rsp_ready = 1'b0;
        req_valid = mask;
        #1;
        g = model_grant(mask, model_ptr);
        checks++; if (req_ready !== onehot(g)) begin errors++; $display("FAIL bp_grant got %b exp %b", req_ready, onehot(g)); end
        tick();
        model_ptr = (g + 1) % NR;
        mask[g] = 1'b0;
        req_valid = mask;
        rand_core();
        ear = core_aligned_ref; eaq = core_aligned_query; el = core_alignment_length;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 60) begin tick(); n++; end
        checks++; if (n !== stub_delay + 1) begin errors++; $display("FAIL bp_latency got %0d exp %0d", n, stub_delay + 1); end
        for (int i = 0; i < 10; i++) begin
            checks++; if ({rsp_valid, rsp_id, rsp_length, rsp_timeout, req_ready, busy} !== {1'b1, IDW'(g), el, 1'b0, {NR{1'b0}}, 1'b1}) begin errors++; $display("FAIL bp_hold%0d got v %b id %0d len %0d rdy %b busy %b exp 1 %0d %0d 0000 1", i, rsp_valid, rsp_id, rsp_length, req_ready, busy, g, el); end
            checks++; if ({rsp_aligned_ref, rsp_aligned_query} !== {ear, eaq}) begin errors++; $display("FAIL bp_data%0d got %h %h exp %h %h", i, rsp_aligned_ref, rsp_aligned_query, ear, eaq); end
            rand_core();
            force_done = (i == 3);
            tick();
        end
        force_done = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        g = model_grant(mask, model_ptr);
        checks++; if ({rsp_valid, busy, req_ready} !== {2'b00, onehot(g)}) begin errors++; $display("FAIL bp_next got v %b busy %b rdy %b exp 0 0 %b", rsp_valid, busy, req_ready, onehot(g)); end
        er = req_ref_seq[g*RB +: RB];
        stub_delay = 3;
        tick();
        model_ptr = (g + 1) % NR;
        req_valid = '0;
        checks++; if ({core_start, core_ref_seq} !== {1'b1, er}) begin errors++; $display("FAIL bp_next_start got %b %h exp 1 %h", core_start, core_ref_seq, er); end
        rsp_ready = 1'b1;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 60) begin tick(); n++; end
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        int g, d, n, bp, lat;
        bit to;
        logic [NR-1:0] mask;
        logic [RB-1:0] er;
        logic [QB-1:0] eq;
        logic [AB-1:0] ear, eaq;
        logic [7:0] el;
        for (int j = 0; j < 25; j++) begin
            mask = NR'($urandom_range(1, (1 << NR) - 1));
            rand_slots();
            req_valid = mask;
            d = $urandom_range(1, TO + 3);
            stub_en = 1'b1; stub_delay = d; rsp_ready = 1'b0;
            #1;
            g = model_grant(mask, model_ptr);
            checks++; if (req_ready !== onehot(g)) begin errors++; $display("FAIL rnd_grant%0d got %b exp %b", j, req_ready, onehot(g)); end
            er = req_ref_seq[g*RB +: RB];
            eq = req_query_seq[g*QB +: QB];
            tick();
            model_ptr = (g + 1) % NR;
            req_valid = NR'($urandom());
            rand_slots();
            rand_core();
            to = (d > TO);
            lat = to ? TO + 1 : d + 1;
            ear = to ? '0 : core_aligned_ref;
            eaq = to ? '0 : core_aligned_query;
            el  = to ? 8'd0 : core_alignment_length;
            #1;
            checks++; if ({core_start, core_ref_seq, core_query_seq, req_ready} !== {1'b1, er, eq, {NR{1'b0}}}) begin errors++; $display("FAIL rnd_start%0d got %b %h %h %b exp 1 %h %h 0", j, core_start, core_ref_seq, core_query_seq, req_ready, er, eq); end
            n = 0;
            while (rsp_valid !== 1'b1 && n < 80) begin tick(); n++; end
            checks++; if (n !== lat) begin errors++; $display("FAIL rnd_latency%0d got %0d exp %0d", j, n, lat); end
            checks++; if ({rsp_id, rsp_timeout, rsp_length, rsp_aligned_ref, rsp_aligned_query, core_ref_seq} !== {IDW'(g), to, el, ear, eaq, er}) begin errors++; $display("FAIL rnd_rsp%0d got id %0d to %b len %0d exp %0d %b %0d", j, rsp_id, rsp_timeout, rsp_length, g, to, el); end
            bp = $urandom_range(0, 3);
            for (int k = 0; k < bp; k++) begin
                tick();
                checks++; if ({rsp_valid, rsp_length} !== {1'b1, el}) begin errors++; $display("FAIL rnd_hold%0d got %b %0d exp 1 %0d", j, rsp_valid, rsp_length, el); end
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd_drop%0d got %b exp 0", j, rsp_valid); end
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_reset_mid_run();
        test_round_robin();
        test_timeout();
        test_collision();
        test_backpressure();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
